// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the EXE stage.
// Fixed 34-cycle latency through a start/busy/done handshake; quotient goes to LO, remainder to HI.
module exe_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             EXE_DivStart,
    input  logic             EXE_DivSigned,
    input  logic [WIDTH-1:0] EXE_ResultA,
    input  logic [WIDTH-1:0] EXE_ResultB,
    input  logic             EXE_Flush,
    output logic             EXE_DivBusy,
    output logic             EXE_DivDone,
    output logic [WIDTH-1:0] EXE_DivQuot,
    output logic [WIDTH-1:0] EXE_DivRem
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quot, divisor;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] quot_out, rem_out;

    logic             accept, last_step;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] rem_step, quot_step;

    // Next-state logic; flush dominates both a new start and an in-flight divide.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_step  = 1'b0;
        case (state)
            IDLE: begin
                if (EXE_DivStart && !EXE_Flush) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                last_step = (cnt == CW'(WIDTH - 1));
                if (EXE_Flush) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand conditioning and one restoring step over the {rem, quot} pair.
    always_comb begin
        a_abs = (EXE_DivSigned && EXE_ResultA[WIDTH-1]) ? -EXE_ResultA : EXE_ResultA;
        b_abs = (EXE_DivSigned && EXE_ResultB[WIDTH-1]) ? -EXE_ResultB : EXE_ResultB;

        shifted = {rem, quot[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};

        if (!trial[WIDTH]) begin
            rem_step  = trial[WIDTH-1:0];
            quot_step = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_step  = shifted[WIDTH-1:0];
            quot_step = {quot[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quot_out <= '0;
            rem_out  <= '0;
        end else if (accept) begin
            cnt     <= '0;
            rem     <= '0;
            quot    <= a_abs;
            divisor <= b_abs;
            neg_q   <= EXE_DivSigned && (EXE_ResultA[WIDTH-1] ^ EXE_ResultB[WIDTH-1]);
            neg_r   <= EXE_DivSigned && EXE_ResultA[WIDTH-1];
        end else if (state == CALC && !EXE_Flush) begin
            cnt  <= cnt + 1'b1;
            rem  <= rem_step;
            quot <= quot_step;
            // Result registers only move on the final step, so they hold across CALC and flushes.
            if (last_step) begin
                quot_out <= neg_q ? -quot_step : quot_step;
                rem_out  <= neg_r ? -rem_step  : rem_step;
            end
        end
    end

    assign EXE_DivBusy = (state != IDLE);
    assign EXE_DivDone = (state == DONE);
    assign EXE_DivQuot = quot_out;
    assign EXE_DivRem  = rem_out;

endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: stimulus pushes model results, a negedge monitor checks each done.
module tb_exe_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        EXE_DivStart, EXE_DivSigned, EXE_Flush;
    logic [31:0] EXE_ResultA, EXE_ResultB;
    logic        EXE_DivBusy, EXE_DivDone;
    logic [31:0] EXE_DivQuot, EXE_DivRem;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] prev_q = '0, prev_r = '0;

    exe_div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .EXE_DivStart (EXE_DivStart),
        .EXE_DivSigned(EXE_DivSigned),
        .EXE_ResultA  (EXE_ResultA),
        .EXE_ResultB  (EXE_ResultB),
        .EXE_Flush    (EXE_Flush),
        .EXE_DivBusy  (EXE_DivBusy),
        .EXE_DivDone  (EXE_DivDone),
        .EXE_DivQuot  (EXE_DivQuot),
        .EXE_DivRem   (EXE_DivRem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: divide magnitudes with wide integer arithmetic, then apply MIPS sign rules.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint      ma, mb, q, r;
        logic [31:0] qq, rr;
        ma = longint'({32'b0, a});
        mb = longint'({32'b0, b});
        if (s && a[31]) ma = 64'h1_0000_0000 - ma;
        if (s && b[31]) mb = 64'h1_0000_0000 - mb;
        if (mb == 0) begin
            q = 64'hFFFF_FFFF;
            r = ma;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        qq = q[31:0];
        rr = r[31:0];
        if (s && (a[31] ^ b[31])) qq = -qq;
        if (s && a[31]) rr = -rr;
        return {qq, rr};
    endfunction

    always @(negedge clk) begin
        if (resetn && EXE_DivDone) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1, required done=0 (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quot", EXE_DivQuot, e.q);
                chk("rem", EXE_DivRem, e.r);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic next_cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; that cycle is cycle 0 of the divide.
    task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b, input bit expect_accept);
        logic [63:0] res;
        EXE_DivStart  = 1'b1;
        EXE_DivSigned = s;
        EXE_ResultA   = a;
        EXE_ResultB   = b;
        if (expect_accept) begin
            exp_t e;
            res    = ref_div(s, a, b);
            e.q    = res[63:32];
            e.r    = res[31:0];
            e.cyc  = cyc + 33;
            prev_q = e.q;
            prev_r = e.r;
            sb.push_back(e);
        end
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        start_div(s, a, b, 1'b1);
        next_cycle(1);
        EXE_DivStart = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            if (k > 1) @(negedge clk);
            else @(negedge clk);
            chk("busy", 32'(EXE_DivBusy), 32'd1);
            chk("done", 32'(EXE_DivDone), 32'(k == 33));
        end
        next_cycle(1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int unsigned mode;

        resetn        = 1'b0;
        EXE_DivStart  = 1'b0;
        EXE_DivSigned = 1'b0;
        EXE_Flush     = 1'b0;
        EXE_ResultA   = '0;
        EXE_ResultB   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(EXE_DivBusy), 32'd0);
        chk("reset_done", 32'(EXE_DivDone), 32'd0);
        chk("reset_quot", EXE_DivQuot, 32'd0);
        chk("reset_rem", EXE_DivRem, 32'd0);
        next_cycle(1);
        resetn = 1'b1;
        next_cycle(2);

        // Directed values and boundaries
        run_div(1'b0, 32'd100, 32'd7);
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div(1'b0, 32'd5, 32'd0);
        run_div(1'b0, 32'd7, 32'd0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd0);

        // Second start during CALC is dropped; a start in cycle 34 is accepted
        start_div(1'b0, 32'd9, 32'd2, 1'b1);
        next_cycle(1);
        EXE_DivStart = 1'b0;
        next_cycle(9);
        start_div(1'b0, 32'd50, 32'd5, 1'b0);
        next_cycle(1);
        EXE_DivStart = 1'b0;
        next_cycle(23);
        start_div(1'b0, 32'd50, 32'd5, 1'b1);
        next_cycle(1);
        EXE_DivStart = 1'b0;
        next_cycle(36);

        // Flush in cycle 15: busy drops in cycle 16, no done, outputs keep the previous result
        start_div(1'b0, 32'd1234, 32'd7, 1'b0);
        next_cycle(1);
        EXE_DivStart = 1'b0;
        next_cycle(14);
        EXE_Flush = 1'b1;
        next_cycle(1);
        EXE_Flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(EXE_DivBusy), 32'd0);
        chk("flush_quot_hold", EXE_DivQuot, prev_q);
        chk("flush_rem_hold", EXE_DivRem, prev_r);
        next_cycle(1);

        // Start and flush together in IDLE: start dropped
        start_div(1'b0, 32'd77, 32'd3, 1'b0);
        EXE_Flush = 1'b1;
        next_cycle(1);
        EXE_DivStart = 1'b0;
        EXE_Flush    = 1'b0;
        @(negedge clk);
        chk("start_flush_busy", 32'(EXE_DivBusy), 32'd0);
        next_cycle(40);
        chk("start_flush_quot_hold", EXE_DivQuot, prev_q);

        // Asynchronous reset in the middle of cycle 20
        start_div(1'b0, 32'd1000, 32'd3, 1'b1);
        next_cycle(1);
        EXE_DivStart = 1'b0;
        next_cycle(19);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_busy", 32'(EXE_DivBusy), 32'd0);
        chk("async_done", 32'(EXE_DivDone), 32'd0);
        chk("async_quot", EXE_DivQuot, 32'd0);
        chk("async_rem", EXE_DivRem, 32'd0);
        sb.delete();
        next_cycle(2);
        resetn = 1'b1;
        next_cycle(1);
        run_div(1'b0, 32'd6, 32'd3);

        // Randomized operands, biased towards small divisors, zero and overflow
        for (int i = 0; i < 24; i++) begin
            mode = $urandom_range(0, 9);
            rs   = 1'($urandom_range(0, 1));
            ra   = $urandom;
            rb   = $urandom >> $urandom_range(0, 31);
            if (mode == 0) rb = '0;
            if (mode == 1) begin
                rs = 1'b1;
                ra = 32'h8000_0000;
                rb = '1;
            end
            if (mode == 2) rb = -rb;
            run_div(rs, ra, rb);
        end

        next_cycle(2);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
